// File: rtl/lr_sum_accumulator.sv
// lr_sum_accumulator: accumulates sum x, sum y, sum xy, sum xx and sample count for linear regression.
// Latency: handshake at E0, 8 shift-add multiply cycles, sums update at E9; 1 sample per 10 cycles.
// Backpressure: in_ready only in WAIT; start aborts and re-arms; LR_SUM_SATURATE_EN clamps sums instead of wrapping.
module lr_sum_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  output logic [ACC_W-1:0] sum_x,
  output logic [ACC_W-1:0] sum_y,
  output logic [ACC_W-1:0] sum_xy,
  output logic [ACC_W-1:0] sum_xx,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_MUL  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Latched sample and iterative multiplier state
  logic [7:0]  x_q;
  logic [7:0]  y_q;
  logic        last_q;
  logic [2:0]  bit_idx;
  logic [15:0] xy_q;
  logic [15:0] xx_q;

  logic        hs;
  logic [15:0] x_ext;
  logic [15:0] pp_xy;
  logic [15:0] pp_xx;

  // Extended-width sums: the top bit is the carry out of each accumulator
  logic [ACC_W:0] add_x;
  logic [ACC_W:0] add_y;
  logic [ACC_W:0] add_xy;
  logic [ACC_W:0] add_xx;
  logic [CNT_W:0] add_cnt;

  logic [ACC_W-1:0] nxt_x;
  logic [ACC_W-1:0] nxt_y;
  logic [ACC_W-1:0] nxt_xy;
  logic [ACC_W-1:0] nxt_xx;
  logic [CNT_W-1:0] nxt_cnt;
  logic             carry_any;

  // Wrap or clamp a sum depending on build configuration
  function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] s);
`ifdef LR_SUM_SATURATE_EN
    fold_sum = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    fold_sum = s[ACC_W-1:0];
`endif
  endfunction

  function automatic logic [CNT_W-1:0] fold_cnt(input logic [CNT_W:0] s);
`ifdef LR_SUM_SATURATE_EN
    fold_cnt = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
`else
    fold_cnt = s[CNT_W-1:0];
`endif
  endfunction

  // Moore outputs and next-state; start overrides everything and re-arms
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_IDLE;
      end
      S_WAIT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (bit_idx == 3'd7) begin
          state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        busy      = 1'b1;
        state_nxt = last_q ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (start) begin
      state_nxt = S_WAIT;
    end
  end

  assign hs = in_valid & in_ready & ~start;

  // One multiplier bit per MUL cycle, LSB first
  always_comb begin
    x_ext = {8'd0, x_q};
    pp_xy = y_q[bit_idx] ? (x_ext << bit_idx) : 16'd0;
    pp_xx = x_q[bit_idx] ? (x_ext << bit_idx) : 16'd0;
  end

  // Candidate accumulator values for the ACC cycle, with carry detection
  always_comb begin
    add_x     = {1'b0, sum_x}  + {{(ACC_W-7){1'b0}}, x_q};
    add_y     = {1'b0, sum_y}  + {{(ACC_W-7){1'b0}}, y_q};
    add_xy    = {1'b0, sum_xy} + {{(ACC_W-15){1'b0}}, xy_q};
    add_xx    = {1'b0, sum_xx} + {{(ACC_W-15){1'b0}}, xx_q};
    add_cnt   = {1'b0, count}  + {{CNT_W{1'b0}}, 1'b1};
    nxt_x     = fold_sum(add_x);
    nxt_y     = fold_sum(add_y);
    nxt_xy    = fold_sum(add_xy);
    nxt_xx    = fold_sum(add_xx);
    nxt_cnt   = fold_cnt(add_cnt);
    carry_any = add_x[ACC_W] | add_y[ACC_W] | add_xy[ACC_W] | add_xx[ACC_W] | add_cnt[CNT_W];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: sample latch, shift-add multiplier, accumulators, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      last_q  <= 1'b0;
      bit_idx <= 3'd0;
      xy_q    <= 16'd0;
      xx_q    <= 16'd0;
      sum_x   <= '0;
      sum_y   <= '0;
      sum_xy  <= '0;
      sum_xx  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (start) begin
      // Abort any in-flight sample; nothing of it reaches the sums
      last_q  <= 1'b0;
      bit_idx <= 3'd0;
      xy_q    <= 16'd0;
      xx_q    <= 16'd0;
      sum_x   <= '0;
      sum_y   <= '0;
      sum_xy  <= '0;
      sum_xx  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (hs) begin
            x_q     <= x;
            y_q     <= y;
            last_q  <= in_last;
            bit_idx <= 3'd0;
            xy_q    <= 16'd0;
            xx_q    <= 16'd0;
          end
        end
        S_MUL: begin
          xy_q    <= xy_q + pp_xy;
          xx_q    <= xx_q + pp_xx;
          bit_idx <= bit_idx + 3'd1;
        end
        S_ACC: begin
          sum_x  <= nxt_x;
          sum_y  <= nxt_y;
          sum_xy <= nxt_xy;
          sum_xx <= nxt_xx;
          count  <= nxt_cnt;
          ovf    <= ovf | carry_any;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lr_sum_accumulator.sv
// Bench for lr_sum_accumulator: a default-width instance and a narrow one (ACC_W=16, CNT_W=2)
// share the same stimulus; expected sums for each set are queued at issue time and
// compared by a monitor whenever the wide instance pulses done.
module tb_lr_sum_accumulator;

`ifdef LR_SUM_SATURATE_EN
  localparam int XY_SMALL  = 65535;
  localparam int CNT_SMALL = 3;
`else
  localparam int XY_SMALL  = 64514;
  localparam int CNT_SMALL = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last;
  logic [7:0] x, y;

  logic        b_in_ready, b_busy, b_done, b_ovf;
  logic [23:0] b_sum_x, b_sum_y, b_sum_xy, b_sum_xx;
  logic [7:0]  b_count;

  logic        s_in_ready, s_busy, s_done, s_ovf;
  logic [15:0] s_sum_x, s_sum_y, s_sum_xy, s_sum_xx;
  logic [1:0]  s_count;

  int vecs = 0;
  int errs = 0;
  logic prev_done = 1'b0;

  typedef struct {
    string name;
    int bx, by, bxy, bxx, bc, bo;
    int sx, sy, sxy, sxx, sc, so;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lr_sum_accumulator #(.ACC_W(24), .CNT_W(8)) u_big (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_last(in_last), .x(x), .y(y), .sum_x(b_sum_x), .sum_y(b_sum_y),
    .sum_xy(b_sum_xy), .sum_xx(b_sum_xx), .count(b_count), .busy(b_busy),
    .done(b_done), .ovf(b_ovf)
  );

  lr_sum_accumulator #(.ACC_W(16), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_last(in_last), .x(x), .y(y), .sum_x(s_sum_x), .sum_y(s_sum_y),
    .sum_xy(s_sum_xy), .sum_xx(s_sum_xx), .count(s_count), .busy(s_busy),
    .done(s_done), .ovf(s_ovf)
  );

  function automatic void chk(input string nm, input int act, input int expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  // Monitor: every done pulse pops one expected record and compares both instances
  always @(negedge clk) begin
    if (b_done) begin
      chk("done_single_cycle", int'(prev_done), 0);
      chk("busy_during_done", int'(b_busy), 0);
      chk("small_done", int'(s_done), 1);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".sum_x"},    int'(b_sum_x),  e.bx);
        chk({e.name, ".sum_y"},    int'(b_sum_y),  e.by);
        chk({e.name, ".sum_xy"},   int'(b_sum_xy), e.bxy);
        chk({e.name, ".sum_xx"},   int'(b_sum_xx), e.bxx);
        chk({e.name, ".count"},    int'(b_count),  e.bc);
        chk({e.name, ".ovf"},      int'(b_ovf),    e.bo);
        chk({e.name, ".s_sum_x"},  int'(s_sum_x),  e.sx);
        chk({e.name, ".s_sum_y"},  int'(s_sum_y),  e.sy);
        chk({e.name, ".s_sum_xy"}, int'(s_sum_xy), e.sxy);
        chk({e.name, ".s_sum_xx"}, int'(s_sum_xx), e.sxx);
        chk({e.name, ".s_count"},  int'(s_count),  e.sc);
        chk({e.name, ".s_ovf"},    int'(s_ovf),    e.so);
      end
    end
    prev_done = b_done;
  end

  task automatic push(input string nm, input int bx, by, bxy, bxx, bc, bo,
                      input int sx, sy, sxy, sxx, sc, so);
    exp_t e;
    e.name = nm;
    e.bx = bx; e.by = by; e.bxy = bxy; e.bxx = bxx; e.bc = bc; e.bo = bo;
    e.sx = sx; e.sy = sy; e.sxy = sxy; e.sxx = sxx; e.sc = sc; e.so = so;
    sb.push_back(e);
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a sample and hold it until the handshake edge; waited = cycles in_ready was low
  task automatic send(input logic [7:0] xv, input logic [7:0] yv, input logic lv,
                      input logic drop, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    x = xv;
    y = yv;
    in_last = lv;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (b_in_ready) got = 1'b1;
      else waited++;
    end
    if (!got) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    if (drop) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (b_done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; x = 8'd0; y = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", int'(b_in_ready), 0);
    chk("rst.busy", int'(b_busy), 0);
    chk("rst.done", int'(b_done), 0);
    chk("rst.ovf", int'(b_ovf), 0);
    chk("rst.sum_xy", int'(b_sum_xy), 0);
    chk("rst.count", int'(b_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single sample (3,5)
    pulse_start();
    push("one", 3, 5, 15, 9, 1, 0, 3, 5, 15, 9, 1, 0);
    send(8'd3, 8'd5, 1'b1, 1'b1, w);
    wait_done();

    // Three samples with in_valid held high throughout
    pulse_start();
    push("three", 258, 261, 65035, 65030, 3, 0, 258, 261, 65035, 65030, 3, 0);
    send(8'd1, 8'd2, 1'b0, 1'b0, w);
    send(8'd2, 8'd4, 1'b0, 1'b0, w);
    chk("three.ready_low_1", w, 9);
    send(8'd255, 8'd255, 1'b1, 1'b1, w);
    chk("three.ready_low_2", w, 9);
    wait_done();

    // Overflow on the 16-bit instance
    pulse_start();
    push("ovf", 510, 510, 130050, 130050, 2, 0, 510, 510, XY_SMALL, XY_SMALL, 2, 1);
    send(8'd255, 8'd255, 1'b0, 1'b1, w);
    send(8'd255, 8'd255, 1'b1, 1'b1, w);
    wait_done();

    // Abort in MUL cycle 4 of sample (7,7)
    pulse_start();
    send(8'd1, 8'd1, 1'b0, 1'b1, w);
    send(8'd7, 8'd7, 1'b0, 1'b1, w);
    repeat (4) @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    chk("abort.in_ready", int'(b_in_ready), 1);
    chk("abort.busy", int'(b_busy), 1);
    chk("abort.sum_x", int'(b_sum_x), 0);
    chk("abort.sum_xy", int'(b_sum_xy), 0);
    chk("abort.count", int'(b_count), 0);
    @(posedge clk); #1;
    push("after_abort", 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0);
    send(8'd1, 8'd1, 1'b1, 1'b1, w);
    wait_done();

    // rst during the ACC cycle of the second sample
    pulse_start();
    send(8'd4, 8'd4, 1'b0, 1'b1, w);
    send(8'd9, 8'd9, 1'b0, 1'b1, w);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_acc.in_ready", int'(b_in_ready), 0);
    chk("rst_acc.busy", int'(b_busy), 0);
    chk("rst_acc.sum_x", int'(b_sum_x), 0);
    chk("rst_acc.sum_xx", int'(b_sum_xx), 0);
    chk("rst_acc.count", int'(b_count), 0);
    chk("rst_acc.ovf", int'(b_ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start();
    push("after_rst", 2, 3, 6, 4, 1, 0, 2, 3, 6, 4, 1, 0);
    send(8'd2, 8'd3, 1'b1, 1'b1, w);
    wait_done();

    // Count wrap / clamp on the 2-bit counter
    pulse_start();
    push("cnt", 4, 4, 4, 4, 4, 0, 4, 4, 4, 4, CNT_SMALL, 1);
    send(8'd1, 8'd1, 1'b0, 1'b1, w);
    send(8'd1, 8'd1, 1'b0, 1'b1, w);
    send(8'd1, 8'd1, 1'b0, 1'b1, w);
    send(8'd1, 8'd1, 1'b1, 1'b1, w);
    wait_done();

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errs);
    $fatal(1);
  end

endmodule
